onehot_stabilizer: RTL and testbench

ONEHOT_STABILIZER -- requirements
Module: onehot_stabilizer

---
 rtl/onehot_pkg.sv | 25 ++
 rtl/onehot_enc.sv | 33 +++
 rtl/onehot_stabilizer.sv | 151 +++++++++++++++
 tb/tb_onehot_stabilizer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types and sizes for the one-hot stabilizer: FSM states, sample
// classes, bus widths and the stable-counter width.
package onehot_pkg;

    localparam int ONEHOT_W  = 8;
    localparam int CODE_W    = 3;
    localparam int CNT_W     = 4;
    localparam int ERR_CNT_W = 8;

    // Stabilizer control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        OFFER    = 2'd2,
        WAIT_CHG = 2'd3
    } state_t;

    // Classification of one registered sample of the decoder output.
    typedef enum logic [1:0] {
        VALID = 2'd0,   // exactly one bit set
        ZERO  = 2'd1,   // no bits set
        MULTI = 2'd2    // two or more bits set
    } class_t;

endpackage

// File: rtl/onehot_enc.sv
// Purely combinational 8-to-3 one-hot encoder with a class output that
// tells the caller whether the input was a legal one-hot, all-zero or
// multi-hot. The code output is only meaningful when the class is VALID.
module onehot_enc
    import onehot_pkg::*;
(
    input  logic [ONEHOT_W-1:0] i_onehot,
    output logic [CODE_W-1:0]   o_code,
    output class_t              o_class
);

    // Encode the set bit index and classify the input pattern.
    always_comb begin
        // NOTE: every output gets a default before any conditional code so
        // no path leaves it unassigned, which would infer a latch.
        o_code  = '0;
        o_class = ZERO;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (i_onehot[i]) begin
                o_code = o_code | CODE_W'(i);
            end
        end
        // v & (v-1) clears the lowest set bit: zero result means one bit.
        if (i_onehot == '0) begin
            o_class = ZERO;
        end else if ((i_onehot & (i_onehot - ONEHOT_W'(1))) == '0) begin
            o_class = VALID;
        end else begin
            o_class = MULTI;
        end
    end

endmodule

// File: rtl/onehot_stabilizer.sv
// One-hot stabilizer: registers a possibly glitchy one-hot code, waits for
// it to hold for STABLE_CYCLES consecutive samples, then offers its binary
// index downstream with a valid/ready handshake. The same code is never
// delivered twice without an intervening change of the sample. Multi-hot
// samples raise a one-cycle err_out pulse.
// Optional feature: define ONEHOT_STABILIZER_ERR_CNT_EN to add the 8-bit
// saturating err_cnt output counting multi-hot samples.
module onehot_stabilizer
    import onehot_pkg::*;
#(
    parameter int STABLE_CYCLES = 4   // legal range 1..15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ONEHOT_W-1:0] onehot_in,
    input  logic                ready_in,
    output logic                valid_out,
    output logic [CODE_W-1:0]   code_out,
    output logic                err_out
`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    // Counter value at which one more matching sample completes settling.
    // Unused when STABLE_CYCLES is 1 (IDLE then offers directly).
    localparam logic [CNT_W-1:0] LP_CNT_LAST =
        (STABLE_CYCLES > 1) ? CNT_W'(STABLE_CYCLES - 2) : '0;

    logic [ONEHOT_W-1:0] r_sample;
    logic [ONEHOT_W-1:0] r_cand;
    logic [CNT_W-1:0]    r_cnt;
    state_t              r_state;
    logic                r_valid;
    logic [CODE_W-1:0]   r_code;
    logic                r_err;

    logic [CODE_W-1:0]   w_code;
    class_t              w_class;
    logic                w_match;

    onehot_enc u_enc (
        .i_onehot (r_sample),
        .o_code   (w_code),
        .o_class  (w_class)
    );

    assign w_match = (r_sample == r_cand);

    // Input sampling and multi-hot error flag; every decision uses r_sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= '0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop reads the pre-edge value of every other flop.
            r_sample <= onehot_in;
            r_err    <= (w_class == MULTI);
        end
    end

    // Settle / offer / wait-for-change controller with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_code  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_class == VALID) begin
                        r_cand <= r_sample;
                        if (STABLE_CYCLES == 1) begin
                            r_state <= OFFER;
                            r_valid <= 1'b1;
                            r_code  <= w_code;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    if (w_class != VALID) begin
                        // Zero or multi-hot abandons the candidate.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (!w_match) begin
                        // A different legal code restarts settling on it.
                        r_cand <= r_sample;
                        r_cnt  <= '0;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_state <= OFFER;
                        r_valid <= 1'b1;
                        r_code  <= w_code;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                OFFER: begin
                    // Outputs hold regardless of the input until accepted.
                    if (ready_in) begin
                        r_state <= WAIT_CHG;
                        r_valid <= 1'b0;
                    end
                end

                WAIT_CHG: begin
                    // Any change, including to zero or multi-hot, re-arms.
                    if (!w_match) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_out = r_valid;
    assign code_out  = r_code;
    assign err_out   = r_err;

`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Saturating count of multi-hot samples, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((w_class == MULTI) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // Error counter not built; err_out remains the only error indication.
`endif

endmodule

// File: tb/tb_onehot_stabilizer.sv
// Self-checking bench for onehot_stabilizer: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// run-length reference model.
module tb_onehot_stabilizer;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] onehot_in = '0;
    logic       ready_in = 1'b0;
    logic       valid_out;
    logic [2:0] code_out;
    logic       err_out;
`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    onehot_stabilizer #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .onehot_in (onehot_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .code_out  (code_out),
        .err_out   (err_out)
`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Delivery rule: a legal one-hot sample value seen on S consecutive
    // decision edges is offered; after acceptance nothing is counted until
    // the sample differs from the delivered value (that differing sample is
    // itself not counted).
    logic [7:0] m_sample = '0;
    logic [7:0] m_run_val = '0;
    logic [7:0] m_last = '0;
    int         m_run = 0;
    bit         m_blocked = 1'b0;
    bit         m_valid = 1'b0;
    int         m_code = 0;
    bit         m_err = 1'b0;
    int         m_err_cnt = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_sample = '0; m_run_val = '0; m_last = '0; m_run = 0;
                m_blocked = 1'b0; m_valid = 1'b0; m_code = 0;
                m_err = 1'b0; m_err_cnt = 0;
            end else begin
                automatic logic [7:0] s = m_sample;
                automatic int pc = $countones(s);
                m_err = (pc > 1);
                if (pc > 1 && m_err_cnt < 255) m_err_cnt++;
                if (m_valid) begin
                    if (ready_in) begin
                        m_valid = 1'b0;
                        m_blocked = 1'b1;
                    end
                end else if (m_blocked) begin
                    if (s != m_last) begin
                        m_blocked = 1'b0;
                        m_run = 0;
                    end
                end else if (pc == 1) begin
                    if (m_run > 0 && s == m_run_val) m_run++;
                    else begin
                        m_run = 1;
                        m_run_val = s;
                    end
                    if (m_run == S) begin
                        m_valid = 1'b1;
                        m_last = s;
                        for (int i = 0; i < 8; i++) if (s[i]) m_code = i;
                    end
                end else begin
                    m_run = 0;
                end
                m_sample = onehot_in;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !done) begin
                check("model_valid", int'(valid_out), int'(m_valid));
                check("model_code", int'(code_out), m_code);
                check("model_err", int'(err_out), int'(m_err));
`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
                check("model_err_cnt", int'(err_cnt), m_err_cnt);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        onehot_in = '0;
        ready_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            edges(1);
            seen = valid_out;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        #2;
        check("reset_valid", int'(valid_out), 0);
        check("reset_code", int'(code_out), 0);
        check("reset_err", int'(err_out), 0);

        // Constant 8'h10 with ready: offered after the 5th edge, once.
        do_reset();
        onehot_in = 8'h10; ready_in = 1'b1;
        edges(4);
        check("h10_not_yet", int'(valid_out), 0);
        edges(1);
        check("h10_valid", int'(valid_out), 1);
        check("h10_code", int'(code_out), 4);
        edges(1);
        check("h10_one_cycle", int'(valid_out), 0);
        check("h10_code_held", int'(code_out), 4);
        edges(3);
        check("h10_no_redeliver", int'(valid_out), 0);

        // 8'h04 briefly then 8'h08: only code 3 is delivered.
        do_reset();
        onehot_in = 8'h04; ready_in = 1'b1;
        edges(2);
        onehot_in = 8'h08;
        for (int k = 0; k < 4; k++) begin
            edges(1);
            check("switch_no_early", int'(valid_out), 0);
        end
        edges(1);
        check("switch_valid", int'(valid_out), 1);
        check("switch_code", int'(code_out), 3);

        // Multi-hot glitch inside SETTLE.
        do_reset();
        onehot_in = 8'h20; ready_in = 1'b0;
        edges(3);
        onehot_in = 8'h41;
        edges(1);
        onehot_in = 8'h20;
        edges(1);
        check("glitch_err_pulse", int'(err_out), 1);
        check("glitch_no_offer", int'(valid_out), 0);
        edges(1);
        check("glitch_err_single", int'(err_out), 0);
`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
        check("glitch_err_cnt", int'(err_cnt), 1);
`endif
        edges(2);
        check("glitch_restart_wait", int'(valid_out), 0);
        edges(1);
        check("glitch_restart_valid", int'(valid_out), 1);
        check("glitch_restart_code", int'(code_out), 5);

        // Back-pressure in OFFER while the input changes.
        onehot_in = 8'h01;
        for (int k = 0; k < 10; k++) begin
            edges(1);
            check("hold_valid", int'(valid_out), 1);
            check("hold_code", int'(code_out), 5);
        end
        ready_in = 1'b1;
        edges(1);
        check("accept_drop", int'(valid_out), 0);
        check("accept_code_kept", int'(code_out), 5);
        wait_valid("code0_timeout");
        check("code0_code", int'(code_out), 0);

        // Asynchronous reset in the middle of a cycle during OFFER.
        do_reset();
        onehot_in = 8'h80; ready_in = 1'b0;
        wait_valid("offer7_timeout");
        check("offer7_code", int'(code_out), 7);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(valid_out), 0);
        check("async_rst_code", int'(code_out), 0);
        check("async_rst_err", int'(err_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edges(3);
        check("after_rst_no_xfer", int'(valid_out), 0);

        // 300 multi-hot cycles: err_out every cycle, counter saturates.
        do_reset();
        onehot_in = 8'hFF;
        for (int k = 0; k < 300; k++) begin
            ready_in = 1'($urandom_range(0, 1));
            edges(1);
        end
        check("multi_err_steady", int'(err_out), 1);
`ifdef ONEHOT_STABILIZER_ERR_CNT_EN
        check("multi_err_cnt_sat", int'(err_cnt), 255);
`endif

        // Randomized run against the model.
        do_reset();
        begin
            int hold = 0;
            logic [7:0] cur = 8'h01;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (c > 10 && $urandom_range(0, 599) == 0) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end
                if (hold == 0) begin
                    int r = int'($urandom_range(0, 9));
                    if (r <= 5) begin
                        cur = 8'(1 << $urandom_range(0, 7));
                        hold = int'($urandom_range(1, 9));
                    end else if (r == 6) begin
                        cur = '0;
                        hold = int'($urandom_range(1, 3));
                    end else if (r == 7) begin
                        int b1 = int'($urandom_range(0, 7));
                        int b2 = (b1 + 1 + int'($urandom_range(0, 6))) % 8;
                        cur = 8'((1 << b1) | (1 << b2));
                        hold = 1;
                    end else begin
                        cur = 8'($urandom_range(0, 255));
                        hold = 1;
                    end
                end
                onehot_in = cur;
                hold--;
                ready_in = ($urandom_range(0, 3) != 0);
            end
        end
        edges(2);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
